// File: rtl/rv_perfcnt64.sv
// rv_perfcnt64: 64-bit CSR-visible event counter (mcycle/minstret style).
// Holds a 64-bit count that advances by 0..2 events per cycle. Each 32-bit
// half can be written through the CSR port. Counting can be inhibited.
// A carry out of bit 63 raises a one-cycle overflow pulse and a sticky flag.
module rv_perfcnt64 #(
   parameter logic [63:0] RST_VAL = 64'h0,
   parameter logic [1:0]  MAX_INC = 2'd2
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        inhibit,
   input  logic [1:0]  inc_amt,
   input  logic        wr_lo_en,
   input  logic        wr_hi_en,
   input  logic [31:0] wr_data,
   input  logic        ovf_clr,
   output logic [63:0] cnt_out,
   output logic        ovf_pulse,
   output logic        ovf_sticky
);

   // IDLE: counting inhibited, COUNT: counting, WRHOLD: cycle after a CSR write
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      WRHOLD = 2'd2
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   logic [63:0] cnt_r;
   logic [63:0] next_cnt_s;
   logic        ovf_pulse_r;
   logic        ovf_sticky_r;
   logic        wrap_s;
   logic        wr_any_s;
   logic        inc_en_s;
   logic [1:0]  inc_eff_s;
   logic [64:0] sum_s;

   // Clamp the event count, form the 65-bit sum and decide whether this cycle increments
   always_comb begin
      wr_any_s  = wr_lo_en | wr_hi_en;
      inc_eff_s = inc_amt;
      if (inc_amt > MAX_INC) begin
         inc_eff_s = MAX_INC;
      end else begin
         inc_eff_s = inc_amt;
      end
      sum_s = {1'b0, cnt_r} + {63'd0, inc_eff_s};
      // Inhibit is honoured in the same cycle it is raised, and the cycle after
      // a write never counts so that a CSR write-then-read returns the written value.
      inc_en_s = 1'b0;
      if (!wr_any_s && (state_r != WRHOLD) && !inhibit) begin
         inc_en_s = 1'b1;
      end else begin
         inc_en_s = 1'b0;
      end
   end

   // Next count value and wrap detection; a write takes priority and never wraps
   always_comb begin
      next_cnt_s = cnt_r;
      wrap_s     = 1'b0;
      if (wr_any_s) begin
         // The unwritten half holds. The increment is dropped, so no carry can reach a written half.
         if (wr_lo_en) begin
            next_cnt_s[31:0] = wr_data;
         end else begin
            next_cnt_s[31:0] = cnt_r[31:0];
         end
         if (wr_hi_en) begin
            next_cnt_s[63:32] = wr_data;
         end else begin
            next_cnt_s[63:32] = cnt_r[63:32];
         end
      end else if (inc_en_s) begin
         next_cnt_s = sum_s[63:0];
         wrap_s     = sum_s[64];
      end else begin
         next_cnt_s = cnt_r;
         wrap_s     = 1'b0;
      end
   end

   // Next FSM state: a write forces one WRHOLD cycle, otherwise follow inhibit
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE, COUNT, WRHOLD: begin
            if (wr_any_s) begin
               next_state_s = WRHOLD;
            end else if (inhibit) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = COUNT;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Count and overflow registers; a new wrap wins over ovf_clr in the same cycle
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         cnt_r        <= RST_VAL;
         ovf_pulse_r  <= 1'b0;
         ovf_sticky_r <= 1'b0;
      end else begin
         cnt_r        <= next_cnt_s;
         ovf_pulse_r  <= wrap_s;
         ovf_sticky_r <= wrap_s | (ovf_sticky_r & ~ovf_clr);
      end
   end

   assign cnt_out    = cnt_r;
   assign ovf_pulse  = ovf_pulse_r;
   assign ovf_sticky = ovf_sticky_r;

endmodule

// File: tb/tb_rv_perfcnt64.sv
// tb_rv_perfcnt64: directed plus randomized checks of rv_perfcnt64 against a
// cycle-level arithmetic model of the counter.
module tb_rv_perfcnt64;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        inhibit;
   logic [1:0]  inc_amt;
   logic        wr_lo_en;
   logic        wr_hi_en;
   logic [31:0] wr_data;
   logic        ovf_clr;
   logic [63:0] cnt_out;
   logic        ovf_pulse;
   logic        ovf_sticky;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   longint unsigned m_cnt;
   bit              m_pulse;
   bit              m_sticky;
   bit              m_hold;

   // Free-running clock
   always #5 clk = ~clk;

   rv_perfcnt64 dut (
      .clk        (clk),
      .rst_l      (rst_l),
      .inhibit    (inhibit),
      .inc_amt    (inc_amt),
      .wr_lo_en   (wr_lo_en),
      .wr_hi_en   (wr_hi_en),
      .wr_data    (wr_data),
      .ovf_clr    (ovf_clr),
      .cnt_out    (cnt_out),
      .ovf_pulse  (ovf_pulse),
      .ovf_sticky (ovf_sticky)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt    = 64'd0;
      m_pulse  = 1'b0;
      m_sticky = 1'b0;
      m_hold   = 1'b0;
   endtask

   // One clock of behaviour, computed from the current inputs
   task automatic model_step();
      longint unsigned inc;
      longint unsigned max_val;
      bit wrapped;
      max_val = 64'hFFFF_FFFF_FFFF_FFFF;
      wrapped = 1'b0;
      if (wr_lo_en || wr_hi_en) begin
         if (wr_lo_en) m_cnt[31:0]  = wr_data;
         if (wr_hi_en) m_cnt[63:32] = wr_data;
         m_hold = 1'b1;
      end else begin
         if (!m_hold && !inhibit) begin
            inc = (inc_amt > 2'd2) ? 64'd2 : {62'd0, inc_amt};
            if (inc != 0 && m_cnt > max_val - inc) wrapped = 1'b1;
            m_cnt = m_cnt + inc;
         end
         m_hold = 1'b0;
      end
      m_pulse  = wrapped;
      m_sticky = wrapped | (m_sticky & !ovf_clr);
   endtask

   // Drive inputs for one cycle (called at negedge), step model, check at next negedge
   task automatic cyc(input bit inh, input logic [1:0] inc, input bit wlo, input bit whi,
                      input logic [31:0] d, input bit clr, input string tag);
      inhibit  = inh;
      inc_amt  = inc;
      wr_lo_en = wlo;
      wr_hi_en = whi;
      wr_data  = d;
      ovf_clr  = clr;
      model_step();
      @(posedge clk);
      @(negedge clk);
      check({tag, "/cnt"}, cnt_out, m_cnt);
      check({tag, "/pulse"}, {63'd0, ovf_pulse}, {63'd0, m_pulse});
      check({tag, "/sticky"}, {63'd0, ovf_sticky}, {63'd0, m_sticky});
   endtask

   initial begin
      bit          r_wlo;
      bit          r_whi;
      logic [31:0] r_d;
      rst_l    = 1'b0;
      inhibit  = 1'b0;
      inc_amt  = 2'd0;
      wr_lo_en = 1'b0;
      wr_hi_en = 1'b0;
      wr_data  = 32'd0;
      ovf_clr  = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset/cnt", cnt_out, 64'd0);
      check("reset/pulse", {63'd0, ovf_pulse}, 64'd0);
      check("reset/sticky", {63'd0, ovf_sticky}, 64'd0);
      rst_l = 1'b1;

      // 1: plain counting 1..10
      for (int i = 0; i < 10; i++) cyc(1'b0, 2'd1, 1'b0, 1'b0, 32'd0, 1'b0, "t1");
      check("t1/ten", cnt_out, 64'd10);

      // 2: write lo all-ones, hi zero, then carry into the upper half after a hold cycle
      cyc(1'b0, 2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, "t2wlo");
      cyc(1'b0, 2'd1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, "t2whi");
      cyc(1'b0, 2'd1, 1'b0, 1'b0, 32'd0, 1'b0, "t2hold");
      check("t2/hold_val", cnt_out, 64'h0000_0000_FFFF_FFFF);
      cyc(1'b0, 2'd1, 1'b0, 1'b0, 32'd0, 1'b0, "t2carry");
      check("t2/carry_val", cnt_out, 64'h0000_0001_0000_0000);

      // 3: wrap all-ones + 2 -> 1, pulse one cycle, sticky until cleared
      cyc(1'b0, 2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, "t3wlo");
      cyc(1'b0, 2'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, "t3whi");
      check("t3/wr_no_ovf", {63'd0, ovf_sticky}, 64'd0);
      cyc(1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 1'b0, "t3hold");
      cyc(1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 1'b0, "t3wrap");
      check("t3/wrap_val", cnt_out, 64'h1);
      check("t3/wrap_pulse", {63'd0, ovf_pulse}, 64'd1);
      check("t3/wrap_sticky", {63'd0, ovf_sticky}, 64'd1);
      cyc(1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, "t3after");
      check("t3/pulse_gone", {63'd0, ovf_pulse}, 64'd0);
      cyc(1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b1, "t3clr");
      check("t3/clr_sticky", {63'd0, ovf_sticky}, 64'd0);

      // 4: inhibit freezes count; write still lands
      for (int i = 0; i < 5; i++) cyc(1'b1, 2'd2, 1'b0, 1'b0, 32'd0, 1'b0, "t4inh");
      check("t4/frozen", cnt_out, 64'h1);
      cyc(1'b1, 2'd2, 1'b1, 1'b0, 32'h1234_5678, 1'b0, "t4wr");
      check("t4/wr_val", cnt_out, 64'h0000_0000_1234_5678);

      // 5: ovf_clr together with a new wrap keeps sticky set (inc_amt=3 saturates to 2)
      cyc(1'b0, 2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, "t5w");
      cyc(1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, "t5hold");
      cyc(1'b0, 2'd3, 1'b0, 1'b0, 32'd0, 1'b1, "t5wrap");
      check("t5/sat_val", cnt_out, 64'h1);
      check("t5/set_wins", {63'd0, ovf_sticky}, 64'd1);
      cyc(1'b0, 2'd1, 1'b0, 1'b0, 32'd0, 1'b0, "t5run");

      // 6: asynchronous reset between edges
      inc_amt = 2'd2;
      #2;
      rst_l = 1'b0;
      #1;
      check("t6/async_cnt", cnt_out, 64'd0);
      check("t6/async_pulse", {63'd0, ovf_pulse}, 64'd0);
      check("t6/async_sticky", {63'd0, ovf_sticky}, 64'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      check("t6/held", cnt_out, 64'd0);
      rst_l = 1'b1;
      cyc(1'b0, 2'd1, 1'b0, 1'b0, 32'd0, 1'b0, "t6resume");
      check("t6/resume_val", cnt_out, 64'd1);

      // Randomized traffic, biased towards all-ones writes to provoke wraps
      for (int i = 0; i < 400; i++) begin
         r_wlo = ($urandom_range(0, 7) == 0);
         r_whi = ($urandom_range(0, 7) == 0);
         r_d   = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
         cyc(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), r_wlo, r_whi, r_d,
             ($urandom_range(0, 7) == 0), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
